ptw_mem_responder: RTL and testbench

//  Memory-side responder for page-table-walker PTE reads. Accepts a PTW read (valid/addr held until

---
 rtl/ptw_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_ptw_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_responder.sv
// PTE read responder between the page-table walker and the data-memory arbiter.
// Define PTW_RESP_CACHE_EN to add a single-entry PTE cache in front of the bus.
`ifndef XLEN
`define XLEN 32
`endif

module ptw_mem_responder #(
  parameter int              XLEN           = `XLEN,
  parameter logic [XLEN-1:0] PMEM_BASE      = XLEN'('h8000_0000),
  parameter logic [XLEN-1:0] PMEM_SIZE      = XLEN'('h0100_0000),
  parameter int              TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ptw_req_valid,
  input  logic [XLEN-1:0] ptw_req_addr,
  output logic            ptw_req_ready,
  output logic            ptw_resp_valid,
  output logic [XLEN-1:0] ptw_resp_data,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            access_fault,
  output logic [XLEN-1:0] access_fault_addr,
  input  logic            flush,
  input  logic            snoop_store_valid,
  input  logic [XLEN-1:0] snoop_store_addr
);
  localparam int OFF = (XLEN == 64) ? 3 : 2;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, BUS_REQ, BUS_WAIT, RESPOND, COOLDOWN} state_t;
  state_t state, state_next;

  logic [XLEN-1:0] addr_q, data_q, fault_addr_q, hit_data;
  logic            fault_q, abandoned_q, stale_q;
  logic [CW-1:0]   tmo_cnt;
  logic            legal, hit, timeout, bus_done, drop, stale_set;

  assign legal    = (ptw_req_addr >= PMEM_BASE) && ((ptw_req_addr - PMEM_BASE) < PMEM_SIZE)
                    && (ptw_req_addr[OFF-1:0] == '0);
  assign timeout  = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus_done = (state == BUS_WAIT) && mem_resp_valid && !stale_q;
  assign drop     = abandoned_q || !ptw_req_valid;
  // A granted read we no longer wait for leaves one response in flight; the next one seen is discarded.
  assign stale_set = ((state == BUS_REQ) && mem_req_ready && (state_next != BUS_WAIT))
                  || ((state == BUS_WAIT) && !bus_done && (state_next != BUS_WAIT));

`ifdef PTW_RESP_CACHE_EN
  logic                c_valid, suppress_q, snoop_hits_entry, snoop_hits_req, fill;
  logic [XLEN-OFF-1:0] c_tag;
  logic [XLEN-1:0]     c_data;
  logic                unused_low;

  assign snoop_hits_entry = snoop_store_valid && (snoop_store_addr[XLEN-1:OFF] == c_tag);
  assign snoop_hits_req   = snoop_store_valid && (snoop_store_addr[XLEN-1:OFF] == addr_q[XLEN-1:OFF]);
  assign hit      = c_valid && !flush && (ptw_req_addr[XLEN-1:OFF] == c_tag);
  assign hit_data = c_data;
  assign fill     = bus_done && !drop && !suppress_q && !snoop_hits_req;
  assign unused_low = ^snoop_store_addr[OFF-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid    <= 1'b0;
      c_tag      <= '0;
      c_data     <= '0;
      suppress_q <= 1'b0;
    end else begin
      if (state == IDLE)
        suppress_q <= 1'b0;
      else if ((state == BUS_WAIT) && snoop_hits_req)
        suppress_q <= 1'b1;
      if (fill && !flush) begin
        c_valid <= 1'b1;
        c_tag   <= addr_q[XLEN-1:OFF];
        c_data  <= mem_resp_data;
      end else if (flush || snoop_hits_entry) begin
        c_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;
  assign hit        = 1'b0;
  assign hit_data   = '0;
  assign unused_cfg = flush ^ snoop_store_valid ^ (^snoop_store_addr);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (ptw_req_valid) state_next = (!legal || hit) ? RESPOND : BUS_REQ;
      BUS_REQ:
        if (!ptw_req_valid)     state_next = IDLE;
        else if (timeout)       state_next = RESPOND;
        else if (mem_req_ready) state_next = BUS_WAIT;
      BUS_WAIT:
        if (bus_done || timeout) state_next = drop ? COOLDOWN : RESPOND;
      RESPOND:  state_next = COOLDOWN;
      COOLDOWN: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ptw_req_ready     = (state == RESPOND);
    ptw_resp_valid    = (state == RESPOND);
    ptw_resp_data     = (state == RESPOND) ? data_q : '0;
    access_fault      = (state == RESPOND) && fault_q;
    mem_req_valid     = (state == BUS_REQ);
    mem_req_addr      = (state == BUS_REQ) ? addr_q : '0;
    access_fault_addr = fault_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      data_q       <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      abandoned_q  <= 1'b0;
      stale_q      <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      tmo_cnt <= ((state == BUS_REQ) || (state == BUS_WAIT)) ? tmo_cnt + CW'(1) : '0;
      if (stale_set)           stale_q <= 1'b1;
      else if (mem_resp_valid) stale_q <= 1'b0;
      case (state)
        IDLE:
          if (ptw_req_valid) begin
            addr_q      <= ptw_req_addr;
            abandoned_q <= 1'b0;
            if (!legal) begin
              data_q       <= '0;
              fault_q      <= 1'b1;
              fault_addr_q <= ptw_req_addr;
            end else if (hit) begin
              data_q  <= hit_data;
              fault_q <= 1'b0;
            end
          end
        BUS_REQ:
          if (ptw_req_valid && timeout) begin
            data_q       <= '0;
            fault_q      <= 1'b1;
            fault_addr_q <= addr_q;
          end
        BUS_WAIT: begin
          if (!ptw_req_valid) abandoned_q <= 1'b1;
          if (bus_done) begin
            data_q  <= mem_resp_data;
            fault_q <= 1'b0;
          end else if (timeout && !drop) begin
            data_q       <= '0;
            fault_q      <= 1'b1;
            fault_addr_q <= addr_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ptw_mem_responder.sv
// Randomized PTW/memory traffic checked every cycle against a transaction-level timing model.
`timescale 1ns/1ps
module tb_ptw_mem_responder;
  localparam int          XLEN = 32;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0100_0000;
  localparam int          TMO  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        ptw_req_valid, ptw_req_ready, ptw_resp_valid;
  logic [31:0] ptw_req_addr, ptw_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_resp_data;
  logic        access_fault;
  logic [31:0] access_fault_addr;
  logic        flush, snoop_store_valid;
  logic [31:0] snoop_store_addr;

  always #5 clk = ~clk;

  ptw_mem_responder #(.XLEN(XLEN), .PMEM_BASE(BASE), .PMEM_SIZE(SIZE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .ptw_req_valid(ptw_req_valid), .ptw_req_addr(ptw_req_addr),
    .ptw_req_ready(ptw_req_ready), .ptw_resp_valid(ptw_resp_valid), .ptw_resp_data(ptw_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .access_fault(access_fault), .access_fault_addr(access_fault_addr),
    .flush(flush), .snoop_store_valid(snoop_store_valid), .snoop_store_addr(snoop_store_addr)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected outputs for the current cycle, written by the transaction model
  logic        chk_en = 1'b0;
  logic        exp_mem_valid = 1'b0, exp_pulse = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_mem_addr = '0, exp_data = '0, exp_fault_addr = '0;

  // behavioural single-entry cache image
  bit          m_cvalid = 1'b0;
  logic [29:0] m_ctag = '0;
  logic [31:0] m_cdata = '0;

  int          txn_start = 0, cap_lat = -1, pulses = 0, bus_cycles = 0;
  logic [31:0] cap_data = '0, cap_fault_addr = '0, cap_mem_addr = '0;
  logic        cap_fault = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("mem_req_valid", 32'(mem_req_valid), 32'(exp_mem_valid));
      checkOutput("mem_req_addr", mem_req_addr, exp_mem_addr);
      checkOutput("ptw_req_ready", 32'(ptw_req_ready), 32'(exp_pulse));
      checkOutput("ptw_resp_valid", 32'(ptw_resp_valid), 32'(exp_pulse));
      checkOutput("ptw_resp_data", ptw_resp_data, exp_data);
      checkOutput("access_fault", 32'(access_fault), 32'(exp_fault));
      checkOutput("access_fault_addr", access_fault_addr, exp_fault_addr);
      if (ptw_resp_valid) begin
        cap_lat        = cyc - txn_start;
        cap_data       = ptw_resp_data;
        cap_fault      = access_fault;
        cap_fault_addr = access_fault_addr;
        pulses++;
      end
      if (mem_req_valid) begin
        cap_mem_addr = mem_req_addr;
        bus_cycles++;
      end
    end
  end

  function automatic bit isLegal(input logic [31:0] a);
    longint unsigned ua = 64'(a);
    return (ua >= 64'h8000_0000) && (ua < 64'h8000_0000 + 64'h0100_0000) && (ua % 4 == 0);
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rdy, input logic rv,
                               input logic [31:0] rd, input logic fl, input logic sv, input logic [31:0] sa);
    ptw_req_valid = v; ptw_req_addr = a; mem_req_ready = rdy; mem_resp_valid = rv;
    mem_resp_data = rd; flush = fl; snoop_store_valid = sv; snoop_store_addr = sa;
  endtask

  task automatic setExp(input logic mv, input logic [31:0] ma, input logic p, input logic [31:0] d, input logic f);
    exp_mem_valid = mv; exp_mem_addr = ma; exp_pulse = p; exp_data = d; exp_fault = f;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // quiet cycles; optional stray response at index stray_at and snoop store at index 0
  task automatic idleCycles(input int n, input int stray_at, input logic sv, input logic [31:0] sa);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, $urandom, 1'b0, k == stray_at, $urandom, 1'b0, sv && k == 0, sa);
      setExp(1'b0, '0, 1'b0, '0, 1'b0);
`ifdef PTW_RESP_CACHE_EN
      if (sv && k == 0 && m_cvalid && sa[31:2] == m_ctag) m_cvalid = 1'b0;
`endif
      tick();
    end
  endtask

  // g: grant delay after first bus cycle; r: response delay after grant (-1 never);
  // drop_at: cycle the PTW withdraws (0 never); fl0: flush with the lookup; snoop_at: snoop cycle (0 none)
  task automatic runTxn(input logic [31:0] a, input int g, input int r, input logic [31:0] d,
                        input int drop_at, input bit fl0, input int snoop_at, input logic [31:0] snoop_a);
    bit legal, hit, bus, success, pulse, withdrawn, flt, suppress;
    int grant_at, data_at, end_bus, resp_at, last, mv_end, eff_drop, eff_snoop;
    logic [31:0] rdata;
    logic v, rv;
    legal = isLegal(a);
    hit = 1'b0;
    rdata = '0;
    suppress = 1'b0;
`ifdef PTW_RESP_CACHE_EN
    hit = legal && m_cvalid && !fl0 && (a[31:2] == m_ctag);
    if (hit) rdata = m_cdata;
    if (fl0) m_cvalid = 1'b0;
`endif
    bus       = legal && !hit;
    grant_at  = 1 + g;
    data_at   = (r < 0) ? (1 << 20) : grant_at + 1 + r;
    success   = bus && grant_at <= TMO && data_at <= TMO;
    end_bus   = success ? data_at : TMO;
    eff_drop  = bus ? drop_at : 0;
    withdrawn = eff_drop > 0 && eff_drop < grant_at && eff_drop <= TMO;
    pulse     = !(eff_drop > 0);
    eff_snoop = (success && snoop_at > grant_at && snoop_at <= data_at) ? snoop_at : 0;
    if (!bus) begin
      resp_at = 1; mv_end = 0; flt = !legal;
    end else begin
      resp_at = end_bus + 1;
      mv_end  = (grant_at < TMO) ? grant_at : TMO;
      rdata   = success ? d : '0;
      flt     = !success;
    end
    if (withdrawn) begin
      mv_end = eff_drop; last = eff_drop;
    end else begin
      last = pulse ? resp_at + 1 : resp_at;
    end
    txn_start = cyc;
    for (int k = 0; k <= last; k++) begin
      v  = (k == 0) || ((eff_drop > 0) ? (k < eff_drop) : (k <= resp_at));
      rv = bus && !withdrawn && (k == data_at);
      if (k == last && !withdrawn && $urandom_range(0, 3) == 0) rv = 1'b1;
      if (pulse && k == resp_at && flt) exp_fault_addr = a;
      applyStimulus(v, a, bus && !withdrawn && k == grant_at, rv, (k == data_at) ? d : $urandom,
                    fl0 && k == 0, eff_snoop > 0 && k == eff_snoop, snoop_a);
      setExp(bus && k >= 1 && k <= mv_end, (bus && k >= 1 && k <= mv_end) ? a : '0,
             pulse && k == resp_at, (pulse && k == resp_at) ? rdata : '0, pulse && k == resp_at && flt);
      tick();
    end
`ifdef PTW_RESP_CACHE_EN
    if (eff_snoop > 0) begin
      if (m_cvalid && snoop_a[31:2] == m_ctag) m_cvalid = 1'b0;
      suppress = (snoop_a[31:2] == a[31:2]);
    end
    if (success && pulse && !suppress) begin
      m_cvalid = 1'b1; m_ctag = a[31:2]; m_cdata = d;
    end
`endif
  endtask

  task automatic clearCap();
    cap_lat = -1; cap_data = 32'hDEAD_BEEF; cap_fault = 1'bx; pulses = 0; bus_cycles = 0;
  endtask

  logic [31:0] pool [4] = '{32'h8000_1004, 32'h8000_1008, 32'h8000_2000, 32'h80FF_FFFC};

  initial begin
    logic [31:0] a, sa;
    int sel, g, r, drop_at, snoop_at;
    bit fl0;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    chk_en = 1'b1;
    setExp(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;
    idleCycles(2, -1, 1'b0, '0);

    clearCap();
    runTxn(32'h8000_1004, 0, 1, 32'h2000_0C01, 0, 1'b0, 0, '0);
    checkOutput("t1_data", cap_data, 32'h2000_0C01);
    checkOutput("t1_latency", cap_lat, 4);
    checkOutput("t1_mem_addr", cap_mem_addr, 32'h8000_1004);
    checkOutput("t1_fault", 32'(cap_fault), 0);
    checkOutput("t1_pulses", pulses, 1);

    clearCap();
    runTxn(32'h8000_2000, 0, 0, 32'h1234_5671, 0, 1'b0, 0, '0);
    checkOutput("min_latency", cap_lat, 3);

    clearCap();
    runTxn(32'h0000_1000, 0, 0, '0, 0, 1'b0, 0, '0);
    checkOutput("t2_latency", cap_lat, 1);
    checkOutput("t2_data", cap_data, 0);
    checkOutput("t2_fault", 32'(cap_fault), 1);
    checkOutput("t2_fault_addr", cap_fault_addr, 32'h0000_1000);
    checkOutput("t2_no_bus", bus_cycles, 0);

    clearCap();
    runTxn(32'h8000_1002, 0, 0, '0, 0, 1'b0, 0, '0);
    checkOutput("t3_fault_addr", cap_fault_addr, 32'h8000_1002);
    checkOutput("t3_latency", cap_lat, 1);

    clearCap();
    runTxn(32'h80FF_FFFC, 0, 0, 32'h0000_00F1, 0, 1'b0, 0, '0);
    checkOutput("top_legal_fault", 32'(cap_fault), 0);
    clearCap();
    runTxn(32'h8100_0000, 0, 0, '0, 0, 1'b0, 0, '0);
    checkOutput("past_end_fault", 32'(cap_fault), 1);

    clearCap();
    runTxn(32'h8000_3000, 0, -1, '0, 0, 1'b0, 0, '0);
    checkOutput("t4_latency", cap_lat, 65);
    checkOutput("t4_fault_addr", cap_fault_addr, 32'h8000_3000);
    checkOutput("t4_data", cap_data, 0);
    idleCycles(6, 3, 1'b0, '0);
    clearCap();
    runTxn(32'h8000_3008, 1, 2, 32'hCAFE_0001, 0, 1'b0, 0, '0);
    checkOutput("t4_next_data", cap_data, 32'hCAFE_0001);
    checkOutput("t4_next_latency", cap_lat, 6);

`ifdef PTW_RESP_CACHE_EN
    runTxn(32'h8000_1004, 0, 0, 32'h2000_0C01, 0, 1'b0, 0, '0);
    clearCap();
    runTxn(32'h8000_1004, 0, 0, 32'h5555_5555, 0, 1'b0, 0, '0);
    checkOutput("t5_hit_latency", cap_lat, 1);
    checkOutput("t5_hit_data", cap_data, 32'h2000_0C01);
    checkOutput("t5_hit_no_bus", bus_cycles, 0);
    idleCycles(2, -1, 1'b1, 32'h8000_1004);
    clearCap();
    runTxn(32'h8000_1004, 0, 0, 32'h2000_0C03, 0, 1'b0, 0, '0);
    checkOutput("t5_snoop_latency", cap_lat, 3);
    clearCap();
    runTxn(32'h8000_1004, 0, 0, 32'h2000_0C05, 0, 1'b1, 0, '0);
    checkOutput("t5_flush_latency", cap_lat, 3);
    runTxn(32'h8000_1010, 0, 2, 32'h0000_0AA1, 0, 1'b0, 3, 32'h8000_1010);
    clearCap();
    runTxn(32'h8000_1010, 0, 0, 32'h0000_0BB1, 0, 1'b0, 0, '0);
    checkOutput("t5_suppress_latency", cap_lat, 3);
`endif

    clearCap();
    runTxn(32'h8000_4000, 0, 3, 32'h7777_0001, 3, 1'b0, 0, '0);
    checkOutput("t6_abandon_pulses", pulses, 0);
    clearCap();
    runTxn(32'h8000_4000, 0, 0, 32'h7777_0003, 0, 1'b0, 0, '0);
    checkOutput("t6_refetch_latency", cap_lat, 3);
    clearCap();
    runTxn(32'h8000_5000, 10, 0, '0, 2, 1'b0, 0, '0);
    checkOutput("withdraw_pulses", pulses, 0);
    checkOutput("withdraw_bus_cycles", bus_cycles, 2);

    // reset while BUS_REQ is presenting a request
    txn_start = cyc;
    for (int k = 0; k < 4; k++) begin
      reset = (k == 2);
      applyStimulus(k < 3, 32'h8000_6000, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      setExp(k == 1 || k == 2, (k == 1 || k == 2) ? 32'h8000_6000 : '0, 1'b0, '0, 1'b0);
      if (k == 3) exp_fault_addr = '0;
      tick();
    end
    m_cvalid = 1'b0;
    idleCycles(2, -1, 1'b0, '0);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 11);
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      drop_at = 0; snoop_at = 0; fl0 = ($urandom_range(0, 7) == 0);
      sa = pool[$urandom_range(0, 3)];
      case (sel)
        0: a = $urandom & 32'h7FFF_FFFC;
        1: a = 32'h8100_0000 + ($urandom & 32'h7EFF_FFFC);
        2: a = (BASE + ($urandom & 32'h00FF_FFFC)) | 32'($urandom_range(1, 3));
        default: a = pool[$urandom_range(0, 3)];
      endcase
      if (sel == 3) drop_at = 1 + g + 1 + $urandom_range(0, r);
      if (sel == 4) begin g = $urandom_range(2, 5); drop_at = $urandom_range(1, g); end
      if (sel == 5) snoop_at = 1 + g + 1 + $urandom_range(0, r);
      if (sel == 6 && $urandom_range(0, 9) == 0) r = -1;
      runTxn(a, g, r, $urandom, drop_at, fl0, snoop_at, sa);
      idleCycles((r < 0) ? 3 : $urandom_range(0, 2), (r < 0) ? 1 : -1, 1'b0, '0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
